// File: rtl/bpd_request_tracker.sv
// Branch-predictor request tracker: issues prediction requests, keeps in-flight branches
// in a FIFO, drives in-order training updates and repairs global history on mispredict.
module bpd_request_tracker #(
  parameter int DEPTH    = 8,
  parameter int HIST_LEN = 16,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [63:0]      br_pc,
  output logic             req_valid,
  output logic [63:0]      req_pc,
  output logic [63:0]      req_hist,
  input  logic             req_taken,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_tag,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  output logic             update_valid,
  output logic [63:0]      update_pc,
  output logic [63:0]      update_hist,
  output logic             update_taken,
  output logic             mispredict,
  output logic             resolve_err
);

  localparam int CNT_W = IDX_W + 1;

  function automatic logic [HIST_LEN-1:0] hist_push(input logic [HIST_LEN-1:0] h,
                                                    input logic b);
    return HIST_LEN'({h, b});
  endfunction

  function automatic logic [63:0] zext(input logic [HIST_LEN-1:0] h);
    return 64'(h);
  endfunction

  logic [HIST_LEN-1:0] ghist_q, ghist_d;
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic [63:0]         st_pc_q, st_pc_d;
  logic [HIST_LEN-1:0] st_hist_q, st_hist_d;
  logic [63:0]         fifo_pc_q   [DEPTH];
  logic [63:0]         fifo_pc_d   [DEPTH];
  logic [HIST_LEN-1:0] fifo_hist_q [DEPTH];
  logic [HIST_LEN-1:0] fifo_hist_d [DEPTH];
  logic                fifo_pred_q [DEPTH];
  logic                fifo_pred_d [DEPTH];
  logic                pred_valid_q, pred_valid_d;
  logic                pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]    pred_tag_q, pred_tag_d;
  logic                update_valid_q, update_valid_d;
  logic [63:0]         update_pc_q, update_pc_d;
  logic [63:0]         update_hist_q, update_hist_d;
  logic                update_taken_q, update_taken_d;
  logic                mispredict_q, mispredict_d;
  logic                resolve_err_q, resolve_err_d;

  logic accept;
  logic legal;
  logic mispred;
  logic capture;

  // Stage 1 never accepts while stage 2 is busy, so a free slot is always reserved.
  assign br_ready  = !busy_q && ((count_q + CNT_W'(busy_q)) < CNT_W'(DEPTH)) && !resolve_valid;
  assign accept    = br_valid && br_ready;
  assign req_valid = accept;
  assign req_pc    = br_pc;
  assign req_hist  = zext(ghist_q);

  assign legal   = resolve_valid && (count_q != {CNT_W{1'b0}}) && (resolve_tag == head_q);
  assign mispred = legal && (resolve_taken != fifo_pred_q[head_q]);
  assign capture = busy_q && !mispred;

  assign pred_valid   = pred_valid_q;
  assign pred_taken   = pred_taken_q;
  assign pred_tag     = pred_tag_q;
  assign update_valid = update_valid_q;
  assign update_pc    = update_pc_q;
  assign update_hist  = update_hist_q;
  assign update_taken = update_taken_q;
  assign mispredict   = mispredict_q;
  assign resolve_err  = resolve_err_q;

  // Next-state for the request stage, FIFO pointers, history and registered outputs.
  always_comb begin
    busy_d         = accept;
    fifo_pc_d      = fifo_pc_q;
    fifo_hist_d    = fifo_hist_q;
    fifo_pred_d    = fifo_pred_q;
    head_d         = head_q;
    pred_valid_d   = capture;
    pred_taken_d   = pred_taken_q;
    pred_tag_d     = pred_tag_q;
    update_valid_d = legal;
    update_pc_d    = update_pc_q;
    update_hist_d  = update_hist_q;
    update_taken_d = update_taken_q;
    mispredict_d   = mispred;
    resolve_err_d  = resolve_err_q || (resolve_valid && !legal);

    if (accept) begin
      st_pc_d   = br_pc;
      st_hist_d = ghist_q;
    end else begin
      st_pc_d   = st_pc_q;
      st_hist_d = st_hist_q;
    end

    if (capture) begin
      fifo_pc_d[tail_q]   = st_pc_q;
      fifo_hist_d[tail_q] = st_hist_q;
      fifo_pred_d[tail_q] = req_taken;
      pred_taken_d        = req_taken;
      pred_tag_d          = tail_q;
    end else begin
      pred_taken_d = pred_taken_q;
      pred_tag_d   = pred_tag_q;
    end

    if (legal) begin
      head_d         = head_q + IDX_W'(1);
      update_pc_d    = fifo_pc_q[head_q];
      update_hist_d  = zext(fifo_hist_q[head_q]);
      update_taken_d = resolve_taken;
    end else begin
      head_d = head_q;
    end

    // A mispredict rebuilds history from the resolved branch and drops everything younger.
    if (mispred) begin
      ghist_d = hist_push(fifo_hist_q[head_q], resolve_taken);
      tail_d  = head_q + IDX_W'(1);
      count_d = {CNT_W{1'b0}};
    end else if (capture) begin
      ghist_d = hist_push(ghist_q, req_taken);
      tail_d  = tail_q + IDX_W'(1);
      count_d = legal ? count_q : count_q + CNT_W'(1);
    end else begin
      ghist_d = ghist_q;
      tail_d  = tail_q;
      case (legal)
        1'b1:    count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ghist_q        <= {HIST_LEN{1'b0}};
      head_q         <= {IDX_W{1'b0}};
      tail_q         <= {IDX_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      busy_q         <= 1'b0;
      st_pc_q        <= 64'd0;
      st_hist_q      <= {HIST_LEN{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= 64'd0;
        fifo_hist_q[i] <= {HIST_LEN{1'b0}};
        fifo_pred_q[i] <= 1'b0;
      end
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_tag_q     <= {IDX_W{1'b0}};
      update_valid_q <= 1'b0;
      update_pc_q    <= 64'd0;
      update_hist_q  <= 64'd0;
      update_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      resolve_err_q  <= 1'b0;
    end else begin
      ghist_q        <= ghist_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      st_pc_q        <= st_pc_d;
      st_hist_q      <= st_hist_d;
      fifo_pc_q      <= fifo_pc_d;
      fifo_hist_q    <= fifo_hist_d;
      fifo_pred_q    <= fifo_pred_d;
      pred_valid_q   <= pred_valid_d;
      pred_taken_q   <= pred_taken_d;
      pred_tag_q     <= pred_tag_d;
      update_valid_q <= update_valid_d;
      update_pc_q    <= update_pc_d;
      update_hist_q  <= update_hist_d;
      update_taken_q <= update_taken_d;
      mispredict_q   <= mispredict_d;
      resolve_err_q  <= resolve_err_d;
    end
  end

endmodule

// File: doc/bpd_request_tracker.md
Name: bpd_request_tracker

Overview:
- Core-side initiator for the branch-predictor harness interface.
- Accepts branches from fetch and issues prediction requests (pc, global history).
- Captures the registered prediction and keeps a FIFO of in-flight branches.
- On in-order resolution, drives update requests; on mispredict, repairs speculative global history and flushes younger branches.

Parameters:
- DEPTH, 8: in-flight branch FIFO entries; power of 2, at least 2. IDX_W = log2(DEPTH).
- HIST_LEN, 16: global history bits, 1..64. Zero-extended to 64 bits on req_hist and update_hist.

Ports:
- clock, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-low. Asserted when 0.
- br_valid, input, 1: fetch presents a conditional branch.
- br_ready, output, 1: tracker accepts br_pc this cycle.
- br_pc, input, 64: branch PC.
- req_valid, output, 1: prediction request to predictor.
- req_pc, output, 64: request PC.
- req_hist, output, 64: request history snapshot.
- req_taken, input, 1: predictor result, valid the cycle after req_valid.
- pred_valid, output, 1: prediction delivered to fetch.
- pred_taken, output, 1: predicted direction.
- pred_tag, output, IDX_W: FIFO slot of this branch.
- resolve_valid, input, 1: execute resolves the oldest branch.
- resolve_tag, input, IDX_W: slot being resolved.
- resolve_taken, input, 1: actual direction.
- update_valid, output, 1: training request to predictor.
- update_pc, output, 64: stored PC.
- update_hist, output, 64: stored history snapshot.
- update_taken, output, 1: actual direction.
- mispredict, output, 1: one-cycle pulse, flush younger branches.
- resolve_err, output, 1: sticky protocol-error flag.

Behaviour:
- Reset (reset==0 at posedge):
  - ghist=0, head=tail=count=0, stage-2 busy=0.
  - All valid/pulse outputs 0, resolve_err=0, data outputs 0.
- Handshake and request:
  - br_ready = !busy && (count+busy) < DEPTH && !resolve_valid.
  - Accept when br_valid && br_ready.
  - req_valid = accept, combinational. req_pc=br_pc, req_hist=zero-extended ghist.
  - Set busy; latch pc, the history snapshot and tail.
- Stage 2, cycle after accept:
  - Sample req_taken.
  - Write {pc, hist, pred} into FIFO[tail]; tail++ (wraps mod DEPTH); count++.
  - ghist <= {ghist[HIST_LEN-2:0], req_taken}.
  - Registered pred_valid=1, pred_taken=req_taken, pred_tag=old tail, asserted the following cycle.
  - Clear busy. Throughput is at most 1 branch per 2 cycles.
- Resolve (resolution is in order):
  - Legal resolve: resolve_valid && count>0 && resolve_tag==head.
  - Illegal resolve: set resolve_err; no other effect.
  - Legal resolve pops head (head++, count--).
  - Next cycle, registered: update_valid=1 with the stored pc/hist and update_taken=resolve_taken.
- Mispredict (resolve_taken != stored pred on a legal resolve):
  - ghist <= {stored_hist[HIST_LEN-2:0], resolve_taken}.
  - tail <= head+1 and count <= 0, flushing all younger entries.
  - Any stage-2 capture in the same cycle is discarded: no FIFO write, no pred_valid.
  - mispredict pulses 1 the next cycle, aligned with update_valid.
- Simultaneous stage-2 capture and correct resolve: both take effect, and count is net unchanged.
- Full boundary: capture never overflows, because acceptance reserves a slot.
- Reset mid-operation discards every entry and any pending update, and drives no update_valid.

Test Plan:
1. Reset, then br_pc=0x1000 with req_taken=1 → req_hist=0; pred_valid a cycle later with pred_tag=0, pred_taken=1; ghist=0x0001.
2. Three branches predicted 1,0,1, then resolve tags 0,1,2 with matching directions → 3 update_valid, update_hist 0x0000, 0x0001, 0x0002; mispredict never asserted.
3. Branches predicted 1,1,1; resolve tag 0 with taken=0 → mispredict pulse; count=0; next req_hist=0x0000; next pred_tag=1.
4. Fill 8 entries without resolving → br_ready=0 with count=8. Resolve one → br_ready returns; the next branch gets tag 0 (wrap).
5. resolve_tag=3 while head=0, and resolve while empty → resolve_err=1 sticky; no update_valid; FIFO unchanged.
6. Mispredict on the same cycle as a stage-2 capture → no pred_valid for the captured branch; count=0; reset==0 mid-stream clears all outputs the next cycle.
